// File: rtl/rv_pkg.sv
// Shared core parameters and slot-index helpers for the operand-read path.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NLANE = 4;
    localparam int NRD   = 8;
    localparam int NWR   = 4;

    function automatic int rs1_slot(input int k);
        return 2 * k;
    endfunction

    function automatic int rs2_slot(input int k);
        return 2 * k + 1;
    endfunction

endpackage

// File: rtl/regread_stage_bypass_mux.sv
// Per-slot operand select: x0, same-cycle writeback, or register-file data.
module bypass_mux
    import rv_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0]     i_addr,
    input  logic [XLEN-1:0]      i_rdata,
    input  logic [NWR-1:0]       i_we,
    input  logic [NWR*WIDTH-1:0] i_waddr,
    input  logic [NWR*XLEN-1:0]  i_wdata,
    output logic [XLEN-1:0]      o_op
);

    // Ascending scan: the last match (highest port) wins, like the file.
    always_comb begin
        o_op = i_rdata;
        for (int p = 0; p < NWR; p++) begin
            if (i_we[p] && (i_waddr[p*WIDTH +: WIDTH] == i_addr)) begin
                o_op = i_wdata[p*XLEN +: XLEN];
            end
        end
        if (i_addr == '0) begin
            o_op = '0;
        end
    end

endmodule

// File: rtl/regread_stage.sv
// Operand-read stage: drives file reads, bypasses writebacks, and
// registers four lanes of operands behind a valid/ready handshake.
module regread_stage
    import rv_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int TAGW  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic [NLANE-1:0]      i_valid,
    input  logic [NLANE*TAGW-1:0] i_tag,
    input  logic [NRD*WIDTH-1:0]  i_rs,
    output logic                  o_ready,
    output logic [NRD*WIDTH-1:0]  o_raddr,
    input  logic [NRD*XLEN-1:0]   i_rdata,
    input  logic [NWR-1:0]        i_we,
    input  logic [NWR*WIDTH-1:0]  i_waddr,
    input  logic [NWR*XLEN-1:0]   i_wdata,
    output logic [NLANE-1:0]      o_valid,
    output logic [NLANE*TAGW-1:0] o_tag,
    output logic [NRD*XLEN-1:0]   o_op,
    input  logic                  i_ready
);

    logic [NLANE-1:0]      r_valid;
    logic [NLANE*TAGW-1:0] r_tag;
    logic [NRD*XLEN-1:0]   r_op;
    logic [NRD*XLEN-1:0]   w_op;
    logic                  w_full;
    logic                  w_load;

    assign o_raddr = i_rs;
    assign w_full  = |r_valid;
    assign o_ready = !w_full | i_ready;
    assign w_load  = (|i_valid) & o_ready & !i_flush;

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        localparam int S1 = rs1_slot(k);
        localparam int S2 = rs2_slot(k);

        bypass_mux #(.WIDTH(WIDTH)) u_rs1 (
            .i_addr  (i_rs[S1*WIDTH +: WIDTH]),
            .i_rdata (i_rdata[S1*XLEN +: XLEN]),
            .i_we    (i_we),
            .i_waddr (i_waddr),
            .i_wdata (i_wdata),
            .o_op    (w_op[S1*XLEN +: XLEN])
        );

        bypass_mux #(.WIDTH(WIDTH)) u_rs2 (
            .i_addr  (i_rs[S2*WIDTH +: WIDTH]),
            .i_rdata (i_rdata[S2*XLEN +: XLEN]),
            .i_we    (i_we),
            .i_waddr (i_waddr),
            .i_wdata (i_wdata),
            .o_op    (w_op[S2*XLEN +: XLEN])
        );
    end

    // Flush beats load and hold; a drain clears valid but keeps the payload.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_tag   <= '0;
            r_op    <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            r_tag   <= i_tag;
            r_op    <= w_op;
        end else if (w_full && i_ready) begin
            r_valid <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_op    = r_op;

endmodule

// File: tb/tb_regread_stage.sv
// Scoreboard bench for regread_stage against a register-file state model.
module tb_regread_stage;

    localparam int W = 5;
    localparam int T = 16;

    typedef struct {
        logic [3:0]   v;
        logic [63:0]  tag;
        logic [255:0] op;
    } exp_t;

    logic         clk = 0;
    logic         i_rst = 1;
    logic         i_flush = 0;
    logic [3:0]   i_valid = '0;
    logic [63:0]  i_tag = '0;
    logic [39:0]  i_rs = '0;
    logic         o_ready;
    logic [39:0]  o_raddr;
    logic [255:0] i_rdata = '0;
    logic [3:0]   i_we = '0;
    logic [19:0]  i_waddr = '0;
    logic [127:0] i_wdata = '0;
    logic [3:0]   o_valid;
    logic [63:0]  o_tag;
    logic [255:0] o_op;
    logic         i_ready = 0;

    regread_stage #(.WIDTH(W), .TAGW(T)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_valid(i_valid), .i_tag(i_tag), .i_rs(i_rs),
        .o_ready(o_ready), .o_raddr(o_raddr), .i_rdata(i_rdata),
        .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .o_valid(o_valid), .o_tag(o_tag), .o_op(o_op),
        .i_ready(i_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t        q[$];
    logic [31:0] regs[32];
    logic [31:0] pend[32];
    logic        m_full = 0;
    logic        full_next = 0;
    logic        exp_ready = 1;

    task automatic chk(input string nm, input logic [255:0] a,
                       input logic [255:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // One issue cycle; expected operands are the register values as
    // they stand once this cycle's writebacks have landed (x0 reads 0).
    task automatic step(input logic [3:0] v, input logic [63:0] tag,
                        input logic [39:0] rs, input logic [3:0] we,
                        input logic [19:0] wa, input logic [127:0] wd,
                        input logic rdy, input logic fl);
        logic [31:0]  nr[32];
        logic [255:0] ops;
        logic [255:0] rd;
        logic         ld;
        int           a;
        @(posedge clk);
        #2;
        regs   = pend;
        m_full = full_next;
        nr     = regs;
        for (int p = 0; p < 4; p++)
            if (we[p]) nr[int'(wa[p*5 +: 5])] = wd[p*32 +: 32];
        for (int s = 0; s < 8; s++) begin
            a = int'(rs[s*5 +: 5]);
            rd[s*32 +: 32]  = regs[a];
            ops[s*32 +: 32] = (a == 0) ? 32'd0 : nr[a];
        end
        i_valid = v; i_tag = tag; i_rs = rs; i_rdata = rd;
        i_we = we; i_waddr = wa; i_wdata = wd;
        i_ready = rdy; i_flush = fl;
        exp_ready = !m_full || rdy;
        ld = (v != 0) && exp_ready && !fl;
        if (fl) begin
            if (m_full && q.size() > 0) void'(q.pop_front());
            full_next = 0;
        end else if (ld) begin
            q.push_back('{v: v, tag: tag, op: ops});
            full_next = 1;
        end else if (m_full && rdy) begin
            full_next = 0;
        end else begin
            full_next = m_full;
        end
        pend = nr;
    endtask

    task automatic rnd_step(input logic rdy, input logic fl);
        logic [39:0]  rs;
        logic [19:0]  wa;
        logic [127:0] wd;
        for (int s = 0; s < 8; s++) rs[s*5 +: 5] = 5'($urandom_range(0, 7));
        for (int p = 0; p < 4; p++) begin
            wa[p*5 +: 5]   = 5'($urandom_range(0, 7));
            wd[p*32 +: 32] = $urandom;
        end
        step(4'($urandom), {$urandom, $urandom}, rs, 4'($urandom),
             wa, wd, rdy, fl);
    endtask

    task automatic do_reset_midcycle();
        #4;
        i_valid = '0;
        i_rst   = 1;
        #1;
        chk("rst_valid", 256'(o_valid), 256'(0));
        chk("rst_tag", 256'(o_tag), 256'(0));
        chk("rst_op", o_op, 256'(0));
        #1;
        i_rst = 0;
        q.delete();
        m_full    = 0;
        full_next = 0;
        exp_ready = 1;
        #1;
        chk("rst_ready", 256'(o_ready), 256'(1));
    endtask

    // Monitor: mid-cycle, inputs stable since the drive after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!i_rst) begin
                chk("ready", 256'(o_ready), 256'(exp_ready));
                chk("full", 256'(o_valid != 0), 256'(m_full));
                chk("raddr", 256'(o_raddr), 256'(i_rs));
                if (o_valid != 0 && !i_flush) begin
                    if (q.size() == 0) begin
                        chk("sb_empty", 256'(0), 256'(1));
                    end else begin
                        e = q[0];
                        chk("valid", 256'(o_valid), 256'(e.v));
                        chk("tag", 256'(o_tag), 256'(e.tag));
                        chk("op", o_op, e.op);
                        if (i_ready) void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [39:0] rs;
        for (int r = 0; r < 32; r++) begin
            regs[r] = $urandom;
            pend[r] = regs[r];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", 256'(o_valid), 256'(0));
        chk("init_tag", 256'(o_tag), 256'(0));
        chk("init_op", o_op, 256'(0));
        @(negedge clk);
        i_rst = 0;
        #1;
        chk("init_ready", 256'(o_ready), 256'(1));

        // x5 read straight from the file
        pend[5] = 32'h0000_1234;
        step(4'b0001, 64'h1, 40'd5, 4'b0000, 20'd0, 128'd0, 1'b1, 1'b0);
        // write to x0 must not forward
        step(4'b0001, 64'h2, 40'd0, 4'b0001, 20'd0,
             {96'd0, 32'hFFFF_FFFF}, 1'b1, 1'b0);
        // ports 1 and 3 both write x7: port 3 wins
        pend[7] = 32'h5;
        rs = '0; rs[14:10] = 5'd7;
        step(4'b0001, 64'h3, rs, 4'b1010, {5'd7, 5'd0, 5'd7, 5'd0},
             {32'hB, 32'h0, 32'hA, 32'h0}, 1'b1, 1'b0);
        step(4'b0000, 64'h0, 40'd0, 4'b0000, 20'd0, 128'd0, 1'b1, 1'b0);

        // hold for three cycles while writebacks hit the held sources
        rs = {5'd4, 5'd3, 5'd2, 5'd1, 5'd4, 5'd3, 5'd2, 5'd1};
        step(4'b1111, 64'hABCD, rs, 4'b0000, 20'd0, 128'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(4'b1111, 64'h5555, rs, 4'b1111,
                 {5'd4, 5'd3, 5'd2, 5'd1}, {4{$urandom}}, 1'b0, 1'b0);
        step(4'b0000, 64'h0, rs, 4'b0000, 20'd0, 128'd0, 1'b1, 1'b0);
        step(4'b0000, 64'h0, rs, 4'b0000, 20'd0, 128'd0, 1'b1, 1'b0);

        // flush wins over a load, then a normal load follows
        step(4'b1111, 64'h7777, rs, 4'b0000, 20'd0, 128'd0, 1'b1, 1'b1);
        step(4'b1111, 64'h8888, rs, 4'b0000, 20'd0, 128'd0, 1'b1, 1'b0);
        step(4'b0000, 64'h0, rs, 4'b0000, 20'd0, 128'd0, 1'b1, 1'b0);

        // async reset while full
        step(4'b1111, 64'h9999, rs, 4'b0000, 20'd0, 128'd0, 1'b0, 1'b0);
        step(4'b1111, 64'h9999, rs, 4'b0000, 20'd0, 128'd0, 1'b0, 1'b0);
        do_reset_midcycle();

        for (int i = 0; i < 400; i++)
            rnd_step(1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 15) == 0));

        for (int i = 0; i < 3; i++)
            step(4'b0000, 64'h0, 40'd0, 4'b0000, 20'd0, 128'd0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("sb_drained", 256'(q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
